// File: rtl/pipe_hazard_pkg.sv
// pipe_hazard_pkg: shared types and the forwarding-select helper for the hazard controller.
//   fwd_sel_t  : ALU operand source select (FWD_NONE / FWD_W / FWD_M)
//   hz_state_t : sequencer states (BOOT / RUN / MEM_WAIT / FAULT)
//   fwd_sel()  : select for one source register; the younger M result wins over W
package pipe_hazard_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_W    = 2'b01,
        FWD_M    = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        MEM_WAIT,
        FAULT
    } hz_state_t;

    function automatic fwd_sel_t fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                         input logic [4:0] rd_w, input logic we_m,
                                         input logic we_w);
        return (we_m && rd_m != 5'd0 && rd_m == rs) ? FWD_M :
               (we_w && rd_w != 5'd0 && rd_w == rs) ? FWD_W : FWD_NONE;
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: combinational E-stage forwarding compare for both ALU operands.
//   rs1_i, rs2_i   : source registers of the instruction in E
//   rd_m_i, we_m_i : destination / write enable in M
//   rd_w_i, we_w_i : destination / write enable in W
//   fwd_a_o, fwd_b_o : operand A / B source select
module hazard_fwd_unit
    import pipe_hazard_pkg::*;
(
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic [4:0] rd_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       we_m_i,
    input  logic       we_w_i,
    output fwd_sel_t   fwd_a_o,
    output fwd_sel_t   fwd_b_o
);

    assign fwd_a_o = fwd_sel(rs1_i, rd_m_i, rd_w_i, we_m_i, we_w_i);
    assign fwd_b_o = fwd_sel(rs2_i, rd_m_i, rd_w_i, we_m_i, we_w_i);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer and forwarding control for the five-stage pipeline.
//   clk, reset (async, active-low)
//   Rs1D/Rs2D, Rs1E/Rs2E/RdE, RdM/RdW, RegWriteM/W, ResultSrcE0, PCSrcE, DMemReqM, DMemReadyM
//   StallF..StallW, FlushD, FlushE : same-cycle pipeline register controls
//   ForwardAE/BE : operand selects, MemFault : sticky memory-timeout fault
//   HAZARD_PERF_CNT_EN adds StallCnt/FlushCnt (32-bit wrapping event counters)
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        ResultSrcE0,
    input  logic        PCSrcE,
    input  logic        DMemReqM,
    input  logic        DMemReadyM,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        StallW,
    output logic        FlushD,
    output logic        FlushE,
    output fwd_sel_t    ForwardAE,
    output fwd_sel_t    ForwardBE,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] StallCnt,
    output logic [31:0] FlushCnt,
`endif
    output logic        MemFault
);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    hz_state_t   state_q, state_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic        active, boot, fault, lw_stall, mem_stall, br, ld;

    hazard_fwd_unit u_fwd (
        .rs1_i  (Rs1E),
        .rs2_i  (Rs2E),
        .rd_m_i (RdM),
        .rd_w_i (RdW),
        .we_m_i (RegWriteM),
        .we_w_i (RegWriteW),
        .fwd_a_o(ForwardAE),
        .fwd_b_o(ForwardBE)
    );

    always_comb begin
        boot      = state_q == BOOT;
        fault     = state_q == FAULT;
        active    = state_q == RUN || state_q == MEM_WAIT;
        lw_stall  = ResultSrcE0 && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
        mem_stall = active && DMemReqM && !DMemReadyM;
        // a memory stall holds E, so a pending branch flush is deferred until it releases
        br        = active && !mem_stall && PCSrcE;
        ld        = active && !mem_stall && !PCSrcE && lw_stall;
        StallF    = boot || fault || mem_stall || ld;
        StallD    = fault || mem_stall || ld;
        StallE    = fault || mem_stall;
        StallM    = fault || mem_stall;
        StallW    = fault || mem_stall;
        FlushD    = boot || fault || br;
        FlushE    = boot || fault || br || ld;
        MemFault  = fault;
    end

    // wcnt counts memStall cycles already spent in MEM_WAIT; the cycle that would make
    // the total reach MEM_TIMEOUT moves to FAULT instead
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: if (mem_stall) begin
                state_d = (MEM_TIMEOUT == 1) ? FAULT : MEM_WAIT;
                wcnt_d  = WW'(1);
            end
            MEM_WAIT: if (mem_stall) begin
                state_d = (wcnt_q == WW'(MEM_TIMEOUT - 1)) ? FAULT : MEM_WAIT;
                wcnt_d  = wcnt_q + WW'(1);
            end else begin
                state_d = RUN;
                wcnt_d  = '0;
            end
            FAULT: state_d = FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + 32'(active && StallD);
            flush_cnt_q <= flush_cnt_q + 32'(active && FlushE);
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`endif

endmodule
